// File: rtl/bist_engine.sv
// BIST controller: single normal-mode operation or an LFSR-driven self-test
// compacted into a CRC-8 signature, with a busy watchdog. Optional macro: BIST_GOLDEN_CHECK_EN.
module bist_engine #(
    parameter int                 DATA_W   = 8,
    parameter int                 RES_W    = 16,
    parameter int                 Y_W      = RES_W,
    parameter int                 ITERS    = 256,
    parameter logic [DATA_W-1:0]  SEED_A   = DATA_W'(1),
    parameter logic [DATA_W-1:0]  SEED_B   = DATA_W'(1),
    parameter logic [DATA_W-1:0]  TAPS_A   = DATA_W'('hB8),
    parameter logic [DATA_W-1:0]  TAPS_B   = DATA_W'('hB8),
    parameter logic [7:0]         CRC_POLY = 8'h07,
    parameter int                 TIMEOUT  = 1024,
    parameter logic [7:0]         GOLDEN   = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              test_req,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              dut_rst,
    output logic              dut_start,
    output logic [DATA_W-1:0] dut_a,
    output logic [DATA_W-1:0] dut_b,
    input  logic              dut_busy,
    input  logic [Y_W-1:0]    dut_y,
    output logic [RES_W-1:0]  result,
    output logic [7:0]        test_cnt,
    output logic [7:0]        signature,
    output logic              done,
    output logic              busy,
    output logic              timeout_err,
    output logic              pass
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int IT_W = $clog2(ITERS + 1);
    localparam int IX_W = (RES_W > 1) ? $clog2(RES_W) : 1;

    typedef enum logic [3:0] {
        IDLE, R_START, R_SKIP, R_WAIT, R_OUT,
        T_INIT, T_SHIFT, T_START, T_SKIP, T_WAIT, T_CRC, T_NEXT, T_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
    logic [DATA_W-1:0] dut_a_q, dut_a_d, dut_b_q, dut_b_d;
    logic              dut_rst_q, dut_rst_d, dut_start_q, dut_start_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic [7:0]        test_cnt_q, test_cnt_d, sig_q, sig_d, crc_q, crc_d;
    logic [IT_W-1:0]   iter_q, iter_d;
    logic [IX_W-1:0]   idx_q, idx_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              tmo_q, tmo_d;
    logic              pass_q, pass_d;
    logic              done_c;
    logic              crc_fb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_a_q    <= SEED_A;
            lfsr_b_q    <= SEED_B;
            dut_a_q     <= '0;
            dut_b_q     <= '0;
            dut_rst_q   <= 1'b1;
            dut_start_q <= 1'b0;
            result_q    <= '0;
            test_cnt_q  <= '0;
            sig_q       <= '0;
            crc_q       <= '0;
            iter_q      <= '0;
            idx_q       <= '0;
            wdog_q      <= '0;
            tmo_q       <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_a_q    <= lfsr_a_d;
            lfsr_b_q    <= lfsr_b_d;
            dut_a_q     <= dut_a_d;
            dut_b_q     <= dut_b_d;
            dut_rst_q   <= dut_rst_d;
            dut_start_q <= dut_start_d;
            result_q    <= result_d;
            test_cnt_q  <= test_cnt_d;
            sig_q       <= sig_d;
            crc_q       <= crc_d;
            iter_q      <= iter_d;
            idx_q       <= idx_d;
            wdog_q      <= wdog_d;
            tmo_q       <= tmo_d;
            pass_q      <= pass_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_a_d    = lfsr_a_q;
        lfsr_b_d    = lfsr_b_q;
        dut_a_d     = dut_a_q;
        dut_b_d     = dut_b_q;
        dut_rst_d   = 1'b0;
        dut_start_d = 1'b0;
        result_d    = result_q;
        test_cnt_d  = test_cnt_q;
        sig_d       = sig_q;
        crc_d       = crc_q;
        iter_d      = iter_q;
        idx_d       = idx_q;
        wdog_d      = wdog_q;
        tmo_d       = tmo_q;
        pass_d      = pass_q;
        done_c      = 1'b0;
        crc_fb      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (run_req)       state_d = R_START;
                else if (test_req) state_d = T_INIT;
            end
            R_START: begin
                dut_a_d     = a;
                dut_b_d     = b;
                dut_start_d = 1'b1;
                wdog_d      = '0;
                tmo_d       = 1'b0;
                state_d     = R_SKIP;
            end
            R_SKIP: state_d = R_WAIT;
            R_OUT: begin
                result_d = dut_y[RES_W-1:0];
                done_c   = 1'b1;
                state_d  = IDLE;
            end
            T_INIT: begin
                test_cnt_d = test_cnt_q + 8'd1;
                crc_d      = '0;
                lfsr_a_d   = SEED_A;
                lfsr_b_d   = SEED_B;
                iter_d     = '0;
                tmo_d      = 1'b0;
                pass_d     = 1'b0;
                dut_rst_d  = 1'b1;
                state_d    = T_SHIFT;
            end
            T_SHIFT: begin
                lfsr_a_d  = {lfsr_a_q[DATA_W-2:0], ^(lfsr_a_q & TAPS_A)};
                lfsr_b_d  = {lfsr_b_q[DATA_W-2:0], ^(lfsr_b_q & TAPS_B)};
                dut_rst_d = 1'b1;
                state_d   = T_START;
            end
            T_START: begin
                dut_a_d     = lfsr_a_q;
                dut_b_d     = lfsr_b_q;
                dut_start_d = 1'b1;
                wdog_d      = '0;
                state_d     = T_SKIP;
            end
            T_SKIP: state_d = T_WAIT;
            // Both wait states share the watchdog; an expiry aborts without touching results.
            R_WAIT, T_WAIT: begin
                if (!dut_busy) begin
                    idx_d   = '0;
                    state_d = (state_q == R_WAIT) ? R_OUT : T_CRC;
                end else if (wdog_q == WD_W'(TIMEOUT)) begin
                    tmo_d     = 1'b1;
                    dut_rst_d = 1'b1;
                    pass_d    = 1'b0;
                    done_c    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            T_CRC: begin
                crc_fb = crc_q[7] ^ dut_y[idx_q];
                crc_d  = {crc_q[6:0], 1'b0} ^ (crc_fb ? CRC_POLY : 8'h00);
                idx_d  = idx_q + IX_W'(1);
                if (idx_q == IX_W'(RES_W - 1)) state_d = T_NEXT;
            end
            T_NEXT: begin
                iter_d  = iter_q + IT_W'(1);
                state_d = ((iter_q + IT_W'(1)) == IT_W'(ITERS)) ? T_DONE : T_SHIFT;
            end
            T_DONE: begin
                sig_d   = crc_q;
`ifdef BIST_GOLDEN_CHECK_EN
                pass_d  = (crc_q == GOLDEN);
`endif
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dut_rst     = dut_rst_q;
    assign dut_start   = dut_start_q;
    assign dut_a       = dut_a_q;
    assign dut_b       = dut_b_q;
    assign result      = result_q;
    assign test_cnt    = test_cnt_q;
    assign signature   = sig_q;
    assign done        = done_c;
    assign busy        = (state_q != IDLE);
    assign timeout_err = tmo_q;
`ifdef BIST_GOLDEN_CHECK_EN
    assign pass        = pass_q;
`else
    assign pass        = 1'b0;
`endif

endmodule

// File: tb/tb_bist_engine.sv
// Self-checking bench for bist_engine: behavioural DUT stub plus a reference
// model of the LFSR operand stream and CRC-8 signature.
module tb_bist_engine;

    localparam int         DATA_W  = 8;
    localparam int         RES_W   = 16;
    localparam int         ITERS   = 4;
    localparam int         TIMEOUT = 16;
    localparam logic [7:0] SEED    = 8'h01;
    localparam logic [7:0] TAPS    = 8'hB8;
    localparam logic [7:0] POLY    = 8'h07;
    localparam logic [7:0] GOLDEN  = 8'h00;

    logic              clk, rst, run_req, test_req;
    logic [DATA_W-1:0] a, b;
    logic              dut_rst, dut_start, dut_busy, done, busy, timeout_err, pass;
    logic [DATA_W-1:0] dut_a, dut_b;
    logic [RES_W-1:0]  dut_y, result;
    logic [7:0]        test_cnt, signature;

    int nCompared = 0;
    int nMismatch = 0;

    int          busyLen = 2;
    int          busyCnt = 0;
    bit          hang    = 1'b0;
    int          yMode   = 0;
    logic [15:0] yConst  = 16'h0000;
    logic [15:0] yReg    = 16'h0000;
    logic [7:0]  expCnt  = 8'h00;
    logic [7:0]  seenA[$], seenB[$], expA[$], expB[$];

    bist_engine #(
        .DATA_W(DATA_W), .RES_W(RES_W), .ITERS(ITERS),
        .SEED_A(SEED), .SEED_B(SEED), .TAPS_A(TAPS), .TAPS_B(TAPS),
        .CRC_POLY(POLY), .TIMEOUT(TIMEOUT), .GOLDEN(GOLDEN)
    ) u_dut (
        .clk(clk), .rst(rst), .run_req(run_req), .test_req(test_req),
        .a(a), .b(b), .dut_rst(dut_rst), .dut_start(dut_start),
        .dut_a(dut_a), .dut_b(dut_b), .dut_busy(dut_busy), .dut_y(dut_y),
        .result(result), .test_cnt(test_cnt), .signature(signature),
        .done(done), .busy(busy), .timeout_err(timeout_err), .pass(pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub arithmetic unit: latches a product or a constant on start, busy for busyLen cycles.
    always @(posedge clk) begin
        if (dut_rst) begin
            busyCnt <= 0;
        end else if (dut_start) begin
            busyCnt <= busyLen;
            yReg    <= (yMode == 0) ? ({8'h00, dut_a} * {8'h00, dut_b}) : yConst;
        end else if (busyCnt > 0) begin
            busyCnt <= busyCnt - 1;
        end
        if (dut_start) begin
            seenA.push_back(dut_a);
            seenB.push_back(dut_b);
        end
    end
    assign dut_busy = hang || (busyCnt != 0);
    assign dut_y    = yReg;

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit r, input bit t);
        run_req  = r;
        test_req = t;
        tick();
        run_req  = 1'b0;
        test_req = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    function automatic logic [7:0] crcFeed(input logic [7:0] c, input logic [15:0] y);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 0; i < RES_W; i++) begin
            fb = r[7] ^ y[i];
            r  = {r[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] lfsrNext(input logic [7:0] s);
        return {s[6:0], ^(s & TAPS)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; run_req = 1'b0; test_req = 1'b0; a = '0; b = '0;
        tick();
        tick();
        nCompared++;
        if (dut_rst !== 1'b1) begin
            nMismatch++;
            $display("[TB] FAIL reset_dut_rst: got %b expected 1", dut_rst);
        end
        nCompared++;
        if ({busy, done, dut_start, timeout_err, pass} !== 5'b0) begin
            nMismatch++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, dut_start, timeout_err, pass});
        end
        nCompared++;
        if ({result, test_cnt, signature, dut_a, dut_b} !== 48'h0) begin
            nMismatch++;
            $display("[TB] FAIL reset_data: got %h expected 0", {result, test_cnt, signature, dut_a, dut_b});
        end
        rst = 1'b0;
        tick();
        nCompared++;
        if (dut_rst !== 1'b0) begin
            nMismatch++;
            $display("[TB] FAIL idle_dut_rst: got %b expected 0", dut_rst);
        end
    endtask

    task automatic test_normal();
        for (int n = 0; n < 4; n++) begin
            logic [7:0] ta, tb;
            int         cyc;
            bit         ok;
            ta      = (n == 0) ? 8'd3 : 8'($urandom_range(0, 255));
            tb      = (n == 0) ? 8'd5 : 8'($urandom_range(0, 255));
            busyLen = (n == 0) ? 4 : $urandom_range(1, 6);
            yMode   = 0;
            a = ta; b = tb;
            issue(1'b1, 1'b0);
            waitDone(100, cyc, ok);
            // Busy drops k = busyLen+1 cycles after dut_start; done follows k+2 cycles after R_START.
            nCompared++;
            if (!ok || cyc != busyLen + 3) begin
                nMismatch++;
                $display("[TB] FAIL normal_latency: got %0d (seen=%0d) expected %0d", cyc, ok, busyLen + 3);
            end
            tick();
            nCompared++;
            if (done !== 1'b0) begin
                nMismatch++;
                $display("[TB] FAIL normal_done_single: got %b expected 0", done);
            end
            nCompared++;
            if (result !== {8'h00, ta} * {8'h00, tb}) begin
                nMismatch++;
                $display("[TB] FAIL normal_result: got %h expected %h", result, {8'h00, ta} * {8'h00, tb});
            end
            nCompared++;
            if (busy !== 1'b0 || test_cnt !== expCnt) begin
                nMismatch++;
                $display("[TB] FAIL normal_idle: got busy=%b cnt=%0d expected busy=0 cnt=%0d", busy, test_cnt, expCnt);
            end
        end
    endtask

    task automatic test_selftest(input int mode, input logic [15:0] yc, input string name);
        logic [7:0] sa, sb, crc, expSig;
        logic [15:0] y;
        bit         expPass;
        int         cyc;
        bit         ok;
        yMode   = mode;
        yConst  = yc;
        busyLen = $urandom_range(1, 5);
        sa = SEED; sb = SEED; crc = 8'h00;
        expA.delete(); expB.delete();
        for (int i = 0; i < ITERS; i++) begin
            sa = lfsrNext(sa);
            sb = lfsrNext(sb);
            expA.push_back(sa);
            expB.push_back(sb);
            y   = (mode == 0) ? ({8'h00, sa} * {8'h00, sb}) : yc;
            crc = crcFeed(crc, y);
        end
        expSig = crc;
`ifdef BIST_GOLDEN_CHECK_EN
        expPass = (expSig == GOLDEN);
`else
        expPass = 1'b0;
`endif
        seenA.delete(); seenB.delete();
        issue(1'b0, 1'b1);
        expCnt = expCnt + 8'd1;
        waitDone(3000, cyc, ok);
        nCompared++;
        if (!ok) begin
            nMismatch++;
            $display("[TB] FAIL %s_done: got no done after %0d cycles expected done", name, cyc);
        end
        tick();
        nCompared++;
        if (signature !== expSig) begin
            nMismatch++;
            $display("[TB] FAIL %s_signature: got %02h expected %02h", name, signature, expSig);
        end
        nCompared++;
        if (test_cnt !== expCnt) begin
            nMismatch++;
            $display("[TB] FAIL %s_test_cnt: got %0d expected %0d", name, test_cnt, expCnt);
        end
        nCompared++;
        if (seenA.size() != ITERS) begin
            nMismatch++;
            $display("[TB] FAIL %s_start_count: got %0d expected %0d", name, seenA.size(), ITERS);
        end else begin
            for (int i = 0; i < ITERS; i++) begin
                nCompared++;
                if (seenA[i] !== expA[i] || seenB[i] !== expB[i]) begin
                    nMismatch++;
                    $display("[TB] FAIL %s_operands[%0d]: got %02h/%02h expected %02h/%02h",
                             name, i, seenA[i], seenB[i], expA[i], expB[i]);
                end
            end
        end
        nCompared++;
        if (timeout_err !== 1'b0 || pass !== expPass) begin
            nMismatch++;
            $display("[TB] FAIL %s_flags: got tmo=%b pass=%b expected tmo=0 pass=%b", name, timeout_err, pass, expPass);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] prevRes;
        logic [7:0]  prevSig;
        int          cyc;
        bit          ok;
        prevRes = result;
        prevSig = signature;
        hang = 1'b1;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        issue(1'b1, 1'b0);
        waitDone(100, cyc, ok);
        // Wait begins two cycles after R_START.
        nCompared++;
        if (!ok || cyc != 2 + TIMEOUT) begin
            nMismatch++;
            $display("[TB] FAIL tmo_run_latency: got %0d (seen=%0d) expected %0d", cyc, ok, 2 + TIMEOUT);
        end
        tick();
        nCompared++;
        if (timeout_err !== 1'b1 || dut_rst !== 1'b1 || busy !== 1'b0) begin
            nMismatch++;
            $display("[TB] FAIL tmo_run_flags: got tmo=%b dut_rst=%b busy=%b expected 1 1 0", timeout_err, dut_rst, busy);
        end
        nCompared++;
        if (result !== prevRes || signature !== prevSig) begin
            nMismatch++;
            $display("[TB] FAIL tmo_run_hold: got %h/%02h expected %h/%02h", result, signature, prevRes, prevSig);
        end
        hang = 1'b0;
        tick();
        busyLen = 2;
        yMode = 0;
        a = 8'd11; b = 8'd13;
        issue(1'b1, 1'b0);
        tick();
        nCompared++;
        if (timeout_err !== 1'b0) begin
            nMismatch++;
            $display("[TB] FAIL tmo_clear: got %b expected 0", timeout_err);
        end
        waitDone(100, cyc, ok);
        tick();
        nCompared++;
        if (!ok || result !== 16'd143) begin
            nMismatch++;
            $display("[TB] FAIL tmo_recover_result: got %h expected %h", result, 16'd143);
        end
        prevSig = signature;
        hang = 1'b1;
        issue(1'b0, 1'b1);
        expCnt = expCnt + 8'd1;
        waitDone(100, cyc, ok);
        nCompared++;
        if (!ok || cyc != 4 + TIMEOUT) begin
            nMismatch++;
            $display("[TB] FAIL tmo_test_latency: got %0d (seen=%0d) expected %0d", cyc, ok, 4 + TIMEOUT);
        end
        tick();
        nCompared++;
        if (timeout_err !== 1'b1 || signature !== prevSig || test_cnt !== expCnt || pass !== 1'b0) begin
            nMismatch++;
            $display("[TB] FAIL tmo_test_state: got tmo=%b sig=%02h cnt=%0d pass=%b expected 1 %02h %0d 0",
                     timeout_err, signature, test_cnt, pass, prevSig, expCnt);
        end
        hang = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        int cyc;
        bit ok;
        busyLen = 3;
        yMode = 0;
        a = 8'd7; b = 8'd9;
        issue(1'b1, 1'b1);
        tick();
        test_req = 1'b1;
        tick();
        test_req = 1'b0;
        waitDone(100, cyc, ok);
        tick();
        nCompared++;
        if (!ok || result !== 16'd63 || test_cnt !== expCnt) begin
            nMismatch++;
            $display("[TB] FAIL collision_run: got res=%h cnt=%0d expected res=%h cnt=%0d", result, test_cnt, 16'd63, expCnt);
        end
        tick();
        tick();
        nCompared++;
        if (busy !== 1'b0) begin
            nMismatch++;
            $display("[TB] FAIL collision_ignored_req: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        busyLen = 2;
        yMode = 0;
        issue(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        nCompared++;
        if (busy !== 1'b1) begin
            nMismatch++;
            $display("[TB] FAIL midrst_running: got busy=%b expected 1", busy);
        end
        rst = 1'b1;
        tick();
        nCompared++;
        if (dut_rst !== 1'b1 || {busy, done, dut_start, timeout_err, pass} !== 5'b0) begin
            nMismatch++;
            $display("[TB] FAIL midrst_flags: got dut_rst=%b flags=%b expected 1 00000",
                     dut_rst, {busy, done, dut_start, timeout_err, pass});
        end
        nCompared++;
        if ({result, test_cnt, signature, dut_a, dut_b} !== 48'h0) begin
            nMismatch++;
            $display("[TB] FAIL midrst_data: got %h expected 0", {result, test_cnt, signature, dut_a, dut_b});
        end
        rst = 1'b0;
        expCnt = 8'h00;
        tick();
    endtask

    initial begin
        $display("[TB] bist_engine bench start");
        test_reset();
        test_normal();
        test_selftest(1, 16'h0000, "zero_y");
        test_selftest(1, 16'h0001, "one_y");
        test_selftest(1, 16'($urandom_range(0, 65535)), "rand_y");
        test_selftest(0, 16'h0000, "mult_y");
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
